fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_if.sv | 29 ++
 rtl/fifo_wr_arb.sv | 105 ++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_if.sv
// Handshake bundle between the write requesters, the arbiter and the downstream FIFO.
// The arbiter takes the slave view; the surrounding environment drives the master view.
interface fifo_wr_arb_if #(
   parameter int FIFO_WIDTH = 8,
   parameter int NUM_REQ    = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [FIFO_WIDTH-1:0]         fifo_data_in;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;
   logic [15:0]                   wr_count;

   modport master (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, wr_count
   );

   modport slave (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, wr_count
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-locking write arbiter in front of a single FIFO write port.
// Words pass straight through in the cycle they are accepted; a packet holds the grant until its last word.
module fifo_wr_arb #(
   parameter int FIFO_WIDTH = 8,
   parameter int NUM_REQ    = 4
) (
   input  logic         clk,
   input  logic         rstN,
   fifo_wr_arb_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef logic [ID_W-1:0] id_t;
   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t                stateQ, stateD;
   id_t                   rrPtr, rrPtrD;
   id_t                   owner, ownerD;
   id_t                   sel;
   logic                  xfer;
   logic [15:0]           wrCount;
   logic [NUM_REQ-1:0]    readyVec;
   logic [FIFO_WIDTH-1:0] reqWord [NUM_REQ];

   function automatic id_t nextId(input id_t id);
      return (int'(id) == NUM_REQ - 1) ? '0 : id + id_t'(1);
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign reqWord[i] = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
   end

   // Scanning the search order backwards lets the earliest valid candidate be the last one written.
   always_comb begin
      logic [ID_W:0] idx;
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      idx = '0;
      sel = rrPtr;
      if (stateQ == LOCK) begin
         sel = owner;
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rrPtr} + (ID_W + 1)'(k);
            if (int'(idx) >= NUM_REQ) idx = idx - (ID_W + 1)'(NUM_REQ);
            if (bus.req_valid[id_t'(idx)]) sel = id_t'(idx);
         end
      end
   end

   // Gating with rstN keeps the FIFO write port quiet for the whole reset, not just after the first edge.
   assign xfer = rstN & bus.req_valid[sel] & ~bus.fifo_full;

   always_comb begin
      stateD = stateQ;
      rrPtrD = rrPtr;
      ownerD = owner;
      if (xfer) begin
         unique case (stateQ)
            IDLE: begin
               if (bus.req_last[sel]) begin
                  rrPtrD = nextId(sel);
               end else begin
                  stateD = LOCK;
                  ownerD = sel;
               end
            end
            LOCK: begin
               if (bus.req_last[sel]) begin
                  stateD = IDLE;
                  rrPtrD = nextId(owner);
               end
            end
            default: stateD = IDLE;
         endcase
      end
   end

   always_comb begin
      readyVec = '0;
      if (xfer) readyVec[sel] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stateQ  <= IDLE;
         rrPtr   <= '0;
         owner   <= '0;
         wrCount <= '0;
      end else begin
         stateQ <= stateD;
         rrPtr  <= rrPtrD;
         owner  <= ownerD;
         if (xfer) wrCount <= wrCount + 16'd1;
      end
   end

   assign bus.req_ready    = readyVec;
   assign bus.fifo_wr_en   = xfer;
   assign bus.fifo_data_in = xfer ? reqWord[sel] : '0;
   assign bus.grant_id     = xfer ? sel : '0;
   assign bus.busy         = (stateQ == LOCK);
   assign bus.wr_count     = wrCount;

endmodule
